snake_body_reader: RTL and testbench
====================================

Name: snake_body_reader

Overview:
- Sequential read-out engine for the 10-entry snake body register bank. It is the reader for the indexed writer.
- On a start pulse it snapshots the flattened body bus and streams entries 0..length-1 over a valid/ready interface.
- While streaming, it compares each entry against a query word and reports the first matching index.
- Consumers: the VGA renderer (stream) and collision logic (hit/hit_index).

Parameters:
- NUM_ENTRIES, 10, number of body segments in the flat bus.
- WIDTH, 32, bits per segment entry.
- IDX_W, 4, index width; must satisfy 2**IDX_W > NUM_ENTRIES.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- body_in  in  NUM_ENTRIES*WIDTH  flattened body bus; entry i = body_in[WIDTH*(i+1)-1 : WIDTH*i].
- length  in  WIDTH  number of valid segments; sampled at start.
- query  in  WIDTH  word to match; sampled at start.
- start  in  1  begin a scan; honoured only in IDLE.
- busy  out  1  high in SCAN and DONE.
- entry_valid  out  1  stream data valid.
- entry_ready  in  1  downstream accepts the current entry.
- entry_data  out  WIDTH  current streamed entry.
- entry_index  out  IDX_W  index of entry_data.
- done  out  1  one-cycle pulse at scan completion.
- hit  out  1  a match was found in the last scan; held until the next start.
- hit_index  out  IDX_W  index of the first match; valid when hit=1.

Behaviour:
- Reset is asynchronous and active-high. It forces state IDLE and clears all outputs, the snapshot and the counters to 0. Reset asserted mid-scan aborts the scan with no done pulse.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - start=1 captures body_in into a snapshot register, plus query and len_q.
  - len_q = min(length, NUM_ENTRIES); the comparison is unsigned on the full WIDTH.
  - The counter is cleared, and hit/hit_index are cleared.
  - Next state is SCAN if len_q>0, else DONE.
- SCAN:
  - entry_valid=1; entry_data = snapshot[cnt]; entry_index=cnt.
  - On the entry_valid&&entry_ready handshake: if snapshot[cnt]==query and hit=0, set hit=1 and hit_index=cnt.
  - On the handshake, cnt increments; if cnt==len_q-1, go to DONE.
  - With entry_ready=0, data and index hold stable and valid stays high. Valid never drops before the handshake.
- DONE: done=1 for exactly one cycle, entry_valid=0, then IDLE.
- Timing: start at edge 0 -> entry_valid high after edge 0. With ready tied high, L entries take L cycles, done is high in cycle L+1, and busy falls after it.
- start while busy is ignored; it is neither queued nor restarted.
- body_in changing during a scan has no effect, because only the snapshot is streamed.
- Matching is an exact WIDTH-bit equality. Duplicate matches keep the lowest index.

Optional Feature:
- Macro: SNAKE_READER_SKIP_HEAD_EN.
- Defined: the scan starts at index 1, so the head is excluded (used for self-collision).
  - The counter is initialised to 1.
  - len_q<=1 goes straight to DONE with hit=0.
  - Streamed indices are 1..len_q-1.
- Undefined: the scan starts at index 0 as described above.

Decomposition:
- Shared package snake_pkg holds:
  - constants SNAKE_LEN_MAX=10, SNAKE_ENTRY_W=32, SNAKE_IDX_W=4;
  - state encodings RD_IDLE=2'd0, RD_SCAN=2'd1, RD_DONE=2'd2.
- A single mux sub-module, snake_entry_select, is natural: a combinational slice of the flat snapshot by index.

Test Plan:
- Reset values: assert reset mid-SCAN (len 5, cycle 3) -> same cycle, busy=0, entry_valid=0, hit=0; no done pulse follows.
- Full scan with ready=1:
  - Stimulus: entries i=0..9 hold 32'h100+i; length=10, query=32'h105.
  - Required: 10 consecutive beats with indices 0..9; done in cycle 11; hit=1, hit_index=5.
- Backpressure:
  - Stimulus: length=3, entry_ready toggles 0,0,1,0,1,1.
  - Required: data held stable while ready=0; exactly 3 handshakes with indices 0,1,2; done after the third.
- No match and clamping:
  - Stimulus: length=32'd20, query=32'hDEAD.
  - Required: 10 beats; hit=0; done pulses once.
- Length 0, and start while busy:
  - length=0 -> done high in cycle 1, no entry_valid.
  - start re-pulsed during SCAN -> ignored; beat count unchanged.
- Duplicates and snapshot:
  - Stimulus: entries 2 and 7 both = query; body_in rewritten after start.
  - Required: hit_index=2; streamed data equals the start-time values.
  - With SNAKE_READER_SKIP_HEAD_EN and query matching only entry 0 -> hit=0, first beat has index 1.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants and reader state encoding for the snake body logic.
package snake_pkg;

  localparam int SNAKE_LEN_MAX = 10;
  localparam int SNAKE_ENTRY_W = 32;
  localparam int SNAKE_IDX_W   = 4;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_SCAN = 2'd1,
    RD_DONE = 2'd2
  } rd_state_e;

endpackage

// File: rtl/snake_body_reader_if.sv
// Valid/ready stream carrying body entries and their indices to consumers.
interface snake_body_reader_if
  import snake_pkg::*;
#(
  parameter int WIDTH = SNAKE_ENTRY_W,
  parameter int IDX_W = SNAKE_IDX_W
);

  logic             entry_valid;
  logic             entry_ready;
  logic [WIDTH-1:0] entry_data;
  logic [IDX_W-1:0] entry_index;

  modport master (
    output entry_valid,
    output entry_data,
    output entry_index,
    input  entry_ready
  );

  modport slave (
    input  entry_valid,
    input  entry_data,
    input  entry_index,
    output entry_ready
  );

endinterface

// File: rtl/snake_entry_select.sv
// Combinational slice of one entry out of the flat snapshot; out-of-range
// indices read as zero so a counter parked past the end is harmless.
module snake_entry_select #(
  parameter int NUM_ENTRIES = 10,
  parameter int WIDTH       = 32,
  parameter int IDX_W       = 4
) (
  input  logic [NUM_ENTRIES*WIDTH-1:0] flat,
  input  logic [IDX_W-1:0]             idx,
  output logic [WIDTH-1:0]             data
);

  // one-hot compare mux over all entries
  always_comb begin
    data = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (idx == IDX_W'(i)) data = flat[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/snake_body_reader.sv
// Snapshot-and-stream reader for the snake body bank, with first-match search.
// Optional build macro: SNAKE_READER_SKIP_HEAD_EN (scan starts at index 1,
// excluding the head, for self-collision checks).
//
// state   | meaning
// RD_IDLE | waiting for start; start captures snapshot, query and length
// RD_SCAN | streaming snapshot[cnt], one entry per handshake
// RD_DONE | one-cycle done pulse, then back to idle
module snake_body_reader
  import snake_pkg::*;
#(
  parameter int NUM_ENTRIES = SNAKE_LEN_MAX,
  parameter int WIDTH       = SNAKE_ENTRY_W,
  parameter int IDX_W       = SNAKE_IDX_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_ENTRIES*WIDTH-1:0] body_in,
  input  logic [WIDTH-1:0]             length,
  input  logic [WIDTH-1:0]             query,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         hit,
  output logic [IDX_W-1:0]             hit_index,
  snake_body_reader_if.master          stream
);

`ifdef SNAKE_READER_SKIP_HEAD_EN
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
`else
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(0);
`endif

  rd_state_e                    state, state_n;
  logic [NUM_ENTRIES*WIDTH-1:0] snap;
  logic [WIDTH-1:0]             query_q;
  logic [IDX_W-1:0]             len_q;
  logic [IDX_W-1:0]             len_clamp;
  logic [IDX_W-1:0]             cnt;
  logic [WIDTH-1:0]             sel_data;
  logic                         load;
  logic                         step;

  // clamp on the full-width length so huge values saturate instead of wrapping
  assign len_clamp = (length > WIDTH'(NUM_ENTRIES)) ? IDX_W'(NUM_ENTRIES)
                                                    : length[IDX_W-1:0];

  snake_entry_select #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .WIDTH       (WIDTH),
    .IDX_W       (IDX_W)
  ) u_sel (
    .flat (snap),
    .idx  (cnt),
    .data (sel_data)
  );

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RD_IDLE;
    else       state <= state_n;
  end

  // next-state and datapath strobes
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      RD_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = (len_clamp > FIRST_IDX) ? RD_SCAN : RD_DONE;
        end
      end
      RD_SCAN: begin
        if (stream.entry_ready) begin
          step = 1'b1;
          if (cnt == len_q - IDX_W'(1)) state_n = RD_DONE;
        end
      end
      RD_DONE: state_n = RD_IDLE;
      default: state_n = RD_IDLE;
    endcase
  end

  // snapshot capture, entry counter and first-match tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap      <= '0;
      query_q   <= '0;
      len_q     <= '0;
      cnt       <= '0;
      hit       <= 1'b0;
      hit_index <= '0;
    end else if (load) begin
      snap      <= body_in;
      query_q   <= query;
      len_q     <= len_clamp;
      cnt       <= FIRST_IDX;
      hit       <= 1'b0;
      hit_index <= '0;
    end else if (step) begin
      cnt <= cnt + IDX_W'(1);
      if (!hit && (sel_data == query_q)) begin
        hit       <= 1'b1;
        hit_index <= cnt;
      end
    end
  end

  assign busy               = (state != RD_IDLE);
  assign done               = (state == RD_DONE);
  assign stream.entry_valid = (state == RD_SCAN);
  assign stream.entry_data  = sel_data;
  assign stream.entry_index = cnt;

endmodule

// File: tb/tb_snake_body_reader.sv
// Directed bench for snake_body_reader with a beat scoreboard.
`timescale 1ns/1ps
module tb_snake_body_reader;
  import snake_pkg::*;

  localparam int N  = SNAKE_LEN_MAX;
  localparam int W  = SNAKE_ENTRY_W;
  localparam int IW = SNAKE_IDX_W;
`ifdef SNAKE_READER_SKIP_HEAD_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  typedef struct {
    logic [W-1:0]  d;
    logic [IW-1:0] i;
  } beat_t;

  logic           clock = 1'b0;
  logic           reset;
  logic [N*W-1:0] body_in;
  logic [W-1:0]   length;
  logic [W-1:0]   query;
  logic           start;
  logic           busy;
  logic           done;
  logic           hit;
  logic [IW-1:0]  hit_index;

  snake_body_reader_if sif ();

  snake_body_reader dut (
    .clock     (clock),
    .reset     (reset),
    .body_in   (body_in),
    .length    (length),
    .query     (query),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .hit       (hit),
    .hit_index (hit_index),
    .stream    (sif.master)
  );

  always #5 clock = ~clock;

  beat_t         sb[$];
  logic [W-1:0]  body_m[N];
  int            n_cmp = 0;
  int            n_err = 0;
  int            beats = 0;
  int            dones = 0;
  bit            prev_stall = 1'b0;
  logic [W-1:0]  held_d;
  logic [IW-1:0] held_i;
  bit            exp_hit;
  int            exp_idx;
  int            exp_beats;
  bit            pat[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) body_in[i*W +: W] = body_m[i];
  endtask

  // sample at the falling edge, then advance past the next rising edge
  task automatic cycle();
    beat_t e;
    @(negedge clock);
    if (sif.entry_valid && prev_stall) begin
      check("hold_data", sif.entry_data, held_d);
      check("hold_index", 32'(sif.entry_index), 32'(held_i));
    end
    prev_stall = sif.entry_valid && !sif.entry_ready;
    held_d     = sif.entry_data;
    held_i     = sif.entry_index;
    if (sif.entry_valid && sif.entry_ready) begin
      beats++;
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("beat_data", sif.entry_data, e.d);
        check("beat_index", 32'(sif.entry_index), 32'(e.i));
      end
    end
    if (done) dones++;
    @(posedge clock);
    #1;
  endtask

  task automatic start_scan(input logic [W-1:0] len, input logic [W-1:0] q);
    int lq;
    beat_t e;
    lq        = (len > W'(N)) ? N : int'(len);
    exp_hit   = 1'b0;
    exp_idx   = 0;
    exp_beats = 0;
    for (int i = FIRST; i < lq; i++) begin
      e.d = body_m[i];
      e.i = IW'(i);
      sb.push_back(e);
      exp_beats++;
      if (!exp_hit && body_m[i] == q) begin
        exp_hit = 1'b1;
        exp_idx = i;
      end
    end
    length = len;
    query  = q;
    start  = 1'b1;
    beats  = 0;
    dones  = 0;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_scan(input int mode, input int restart_at, input int rewrite_at);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      if (mode == 1) sif.entry_ready = (k < 6) ? pat[k] : 1'b1;
      start = (k == restart_at);
      if (k == restart_at) length = 32'd3;
      if (k == rewrite_at) begin
        for (int i = 0; i < N; i++) body_m[i] = 32'hBAD0_0000 + W'(i);
        pack();
      end
      cycle();
      n++;
      if (dones > 0) got = 1'b1;
    end
    start           = 1'b0;
    sif.entry_ready = 1'b1;
    check("done_seen", 32'(got), 32'd1);
    if (mode == 0) check("done_cycle", 32'(n), 32'(exp_beats + 1));
    check("beats", 32'(beats), 32'(exp_beats));
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("hit", 32'(hit), 32'(exp_hit));
    if (exp_hit) check("hit_index", 32'(hit_index), 32'(exp_idx));
    cycle();
    check("busy_after", 32'(busy), 32'd0);
    check("done_once", 32'(dones), 32'd1);
  endtask

  task automatic default_body();
    for (int i = 0; i < N; i++) body_m[i] = 32'h100 + W'(i);
    pack();
  endtask

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    length          = '0;
    query           = '0;
    sif.entry_ready = 1'b1;
    default_body();

    // reset state
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_valid", 32'(sif.entry_valid), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // reset asserted mid-scan aborts without done
    start_scan(32'd5, 32'h101);
    repeat (3) cycle();
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(sif.entry_valid), 32'd0);
    check("abort_hit", 32'(hit), 32'd0);
    cycle();
    reset = 1'b0;
    sb.delete();
    dones = 0;
    repeat (6) cycle();
    check("abort_no_done", 32'(dones), 32'd0);

    // full scan, ready held high
    start_scan(32'd10, 32'h105);
    run_scan(0, -1, -1);

    // backpressure
    start_scan(32'd3, 32'h102);
    run_scan(1, -1, -1);

    // no match, length clamped
    start_scan(32'd20, 32'hDEAD);
    run_scan(0, -1, -1);

    // zero length
    start_scan(32'd0, 32'h100);
    run_scan(0, -1, -1);

    // start re-pulsed during scan is ignored
    start_scan(32'd10, 32'h109);
    run_scan(0, 3, -1);

    // duplicates keep lowest index; rewrite after start does not leak through
    default_body();
    body_m[2] = 32'hCAFE;
    body_m[7] = 32'hCAFE;
    pack();
    start_scan(32'd10, 32'hCAFE);
    run_scan(0, -1, 1);

    // only the head matches
    default_body();
    body_m[0] = 32'h77;
    pack();
    start_scan(32'd4, 32'h77);
    run_scan(0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
